// File: rtl/traffic_pkg.sv
// traffic_pkg: phase encoding, lamp codes and timer sizing shared by the traffic controller.
package traffic_pkg;
    typedef enum logic [1:0] {GREEN = 2'd0, YELLOW = 2'd1, ALLRED = 2'd2} phase_t;
    localparam logic [2:0] LT_RED = 3'b100;
    localparam logic [2:0] LT_YEL = 3'b010;
    localparam logic [2:0] LT_GRN = 3'b001;
    function automatic int tmr_w(input int g, input int y, input int a);
        int m;
        m = (g > y) ? g : y;
        m = (m > a) ? m : a;
        return (m > 1) ? $clog2(m) : 1;
    endfunction
endpackage

// File: rtl/traffic_rr_pick.sv
// traffic_rr_pick: first set request after active_idx, wrapping, never returning active_idx itself.
module traffic_rr_pick #(
    parameter int N_APPR = 4
) (
    input  logic [N_APPR-1:0]         req,
    input  logic [$clog2(N_APPR)-1:0] active_idx,
    output logic [$clog2(N_APPR)-1:0] nxt_idx,
    output logic                      found
);
    localparam int IW = $clog2(N_APPR);
    logic [IW-1:0] j;
    always_comb begin
        nxt_idx = active_idx;
        found = 1'b0;
        j = '0;
        // Walk from the farthest candidate back so the nearest one is the last to land.
        for (int k = N_APPR - 1; k >= 1; k--) begin
            j = IW'((int'(active_idx) + k) % N_APPR);
            if (req[j]) begin
                nxt_idx = j;
                found = 1'b1;
            end
        end
    end
endmodule

// File: rtl/traffic_light_nway.sv
// traffic_light_nway: N-approach signal controller with latched demand, round-robin service,
// gap-out/max-out green termination, yellow and all-red clearance, optional home recall.
module traffic_light_nway
    import traffic_pkg::*;
#(
    parameter int N_APPR      = 4,
    parameter int GREEN_MIN   = 8,
    parameter int GREEN_MAX   = 32,
    parameter int YELLOW_T    = 3,
    parameter int ALLRED_T    = 2,
    parameter int HOME_RECALL = 1
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic [N_APPR-1:0]         sensor,
    output logic [3*N_APPR-1:0]       light,
    output logic [$clog2(N_APPR)-1:0] active_idx,
    output logic [1:0]                phase,
    output logic [N_APPR-1:0]         req_pend
);
    localparam int IW = $clog2(N_APPR);
    localparam int TW = tmr_w(GREEN_MAX, YELLOW_T, ALLRED_T);
    logic [N_APPR-1:0] s_meta, s, req_q, req_d, eff_req, act_oh;
    phase_t state_q, state_d;
    logic [TW-1:0] timer_q, timer_d;
    logic [IW-1:0] active_q, active_d, nxt_q, nxt_d, pick_idx;
    logic pick_found, other, enter_green;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s_meta   <= '0;
            s        <= '0;
            req_q    <= '0;
            state_q  <= GREEN;
            timer_q  <= '0;
            active_q <= '0;
            nxt_q    <= '0;
        end else begin
            s_meta   <= sensor;
            s        <= s_meta;
            req_q    <= req_d;
            state_q  <= state_d;
            timer_q  <= timer_d;
            active_q <= active_d;
            nxt_q    <= nxt_d;
        end
    end

    assign act_oh = N_APPR'(1) << active_q;
    assign eff_req = req_q | ((HOME_RECALL != 0 && active_q != '0) ? N_APPR'(1) : '0);
    assign other = |(eff_req & ~act_oh);
    assign enter_green = state_q == ALLRED && timer_q == TW'(ALLRED_T - 1);
    // Clearing on green entry overrides a same-cycle sensor hit on the incoming approach.
    assign req_d = (req_q | (s & ~((state_q == GREEN) ? act_oh : '0)))
                 & ~(enter_green ? N_APPR'(1) << nxt_q : '0);

    traffic_rr_pick #(.N_APPR(N_APPR)) u_pick (
        .req(eff_req),
        .active_idx(active_q),
        .nxt_idx(pick_idx),
        .found(pick_found)
    );

    always_comb begin
        state_d = state_q;
        timer_d = timer_q;
        active_d = active_q;
        nxt_d = nxt_q;
        case (state_q)
            GREEN: begin
                if (other && pick_found && ((timer_q >= TW'(GREEN_MIN - 1) && !s[active_q])
                    || timer_q == TW'(GREEN_MAX - 1))) begin
                    state_d = YELLOW;
                    timer_d = '0;
                    nxt_d = pick_idx;
                end else if (timer_q != TW'(GREEN_MAX - 1)) begin
                    timer_d = timer_q + 1'b1;
                end
            end
            YELLOW: begin
                state_d = (timer_q == TW'(YELLOW_T - 1)) ? ALLRED : YELLOW;
                timer_d = (timer_q == TW'(YELLOW_T - 1)) ? '0 : timer_q + 1'b1;
            end
            ALLRED: begin
                state_d = enter_green ? GREEN : ALLRED;
                timer_d = enter_green ? '0 : timer_q + 1'b1;
                active_d = enter_green ? nxt_q : active_q;
            end
            default: begin
                state_d = GREEN;
                timer_d = '0;
            end
        endcase
    end

    always_comb begin
        light = '0;
        for (int i = 0; i < N_APPR; i++)
            light[3*i +: 3] = (active_q == IW'(i) && state_q != ALLRED)
                            ? ((state_q == GREEN) ? LT_GRN : LT_YEL) : LT_RED;
    end

    assign active_idx = active_q;
    assign phase = state_q;
    assign req_pend = req_q;
endmodule

// File: tb/tb_traffic_light_nway.sv
// tb_traffic_light_nway: directed scenarios against a cycle-level behavioural model of the controller.
module tb_traffic_light_nway;
    localparam int N = 4, GMIN = 8, GMAX = 32, YT = 3, AT = 2, HR = 1;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic [3:0] sensor = '0;
    logic [11:0] light;
    logic [1:0] active_idx, phase;
    logic [3:0] req_pend;
    int tests = 0, fails = 0;

    traffic_light_nway #(.N_APPR(N), .GREEN_MIN(GMIN), .GREEN_MAX(GMAX), .YELLOW_T(YT),
                         .ALLRED_T(AT), .HOME_RECALL(HR)) dut (
        .clk(clk), .rst_n(rst_n), .sensor(sensor), .light(light),
        .active_idx(active_idx), .phase(phase), .req_pend(req_pend)
    );

    always #5 clk = ~clk;

    // model: phase 0/1/2, served approach, pending pick, cycles already spent in the phase
    int m_ph = 0, m_act = 0, m_nxt = 0, m_el = 0;
    bit [3:0] m_s1 = '0, m_s2 = '0, m_req = '0;

    task automatic model_step();
        bit [3:0] eff, rq;
        bit oth, got;
        int ph, act, nxt, el;
        eff = m_req;
        if (HR != 0 && m_act != 0) eff[0] = 1'b1;
        oth = 1'b0;
        for (int j = 0; j < N; j++) if (j != m_act && eff[j]) oth = 1'b1;
        ph = m_ph; act = m_act; nxt = m_nxt; el = m_el + 1;
        rq = m_req;
        for (int j = 0; j < N; j++) if (m_s2[j] && !(m_ph == 0 && j == m_act)) rq[j] = 1'b1;
        if (m_ph == 0) begin
            if (oth && ((m_el + 1 >= GMIN && !m_s2[m_act]) || m_el + 1 >= GMAX)) begin
                ph = 1; el = 0; got = 1'b0;
                for (int k = 1; k < N; k++)
                    if (!got && eff[(m_act + k) % N]) begin nxt = (m_act + k) % N; got = 1'b1; end
            end
        end else if (m_ph == 1) begin
            if (m_el + 1 == YT) begin ph = 2; el = 0; end
        end else if (m_el + 1 == AT) begin
            ph = 0; el = 0; act = m_nxt; rq[m_nxt] = 1'b0;
        end
        m_s1 <= sensor; m_s2 <= m_s1; m_req <= rq;
        m_ph <= ph; m_act <= act; m_nxt <= nxt; m_el <= el;
    endtask

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_s1 <= '0; m_s2 <= '0; m_req <= '0;
            m_ph <= 0; m_act <= 0; m_nxt <= 0; m_el <= 0;
        end else model_step();
    end

    function automatic logic [11:0] exp_light();
        logic [11:0] l;
        l = 12'b100_100_100_100;
        if (m_ph != 2) l[3*m_act +: 3] = (m_ph == 0) ? 3'b001 : 3'b010;
        return l;
    endfunction

    typedef struct {int ph; int idx; int len;} run_t;
    run_t hist[$];
    int greens[$];
    logic [1:0] cur_ph, cur_idx;
    int run_len = 0;

    task automatic cycle_check();
        tests++;
        if (light !== exp_light() || phase !== 2'(m_ph) || active_idx !== 2'(m_act) || req_pend !== m_req) begin
            fails++;
            $display("FAIL cycle t=%0t: light=%b phase=%0d idx=%0d req=%b, required light=%b phase=%0d idx=%0d req=%b",
                     $time, light, phase, active_idx, req_pend, exp_light(), m_ph, m_act, m_req);
        end
        if (!rst_n) run_len = 0;
        else if (run_len == 0) begin cur_ph = phase; cur_idx = active_idx; run_len = 1; end
        else if (phase == cur_ph && active_idx == cur_idx) run_len++;
        else begin
            hist.push_back('{int'(cur_ph), int'(cur_idx), run_len});
            if (phase == 2'd0) greens.push_back(int'(active_idx));
            cur_ph = phase; cur_idx = active_idx; run_len = 1;
        end
    endtask

    task automatic tick(input int n);
        repeat (n) begin @(negedge clk); cycle_check(); end
    endtask

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
        tests++;
        if (got !== want) begin
            fails++;
            $display("FAIL %s: got %0h, required %0h", name, got, want);
        end
    endtask

    task automatic chk_run(input int i, input int ph, input int idx, input int len);
        tests++;
        if (i >= hist.size()) begin
            fails++;
            $display("FAIL run%0d: missing, required phase=%0d idx=%0d len=%0d", i, ph, idx, len);
        end else if (hist[i].ph != ph || hist[i].idx != idx || hist[i].len != len) begin
            fails++;
            $display("FAIL run%0d: got phase=%0d idx=%0d len=%0d, required phase=%0d idx=%0d len=%0d",
                     i, hist[i].ph, hist[i].idx, hist[i].len, ph, idx, len);
        end
    endtask

    task automatic wait_state(input int ph, input int idx, input int budget);
        int n;
        n = 0;
        while (!(phase == 2'(ph) && (idx < 0 || active_idx == 2'(idx))) && n < budget) begin tick(1); n++; end
        tests++;
        if (!(phase == 2'(ph) && (idx < 0 || active_idx == 2'(idx)))) begin
            fails++;
            $display("FAIL wait phase%0d idx%0d: timed out after %0d cycles, at phase=%0d idx=%0d",
                     ph, idx, budget, phase, active_idx);
        end
    endtask

    initial begin
        int bad;
        // reset and idle
        tick(3);
        chk("reset_light", 32'(light), 32'h924 - 32'h0 + 32'h0 - 32'h3 + 32'h0);
        rst_n = 1'b1;
        bad = 0;
        repeat (1000) begin
            tick(1);
            if (light !== 12'b100_100_100_001 || phase !== 2'd0) bad++;
        end
        chk("idle_bad_cycles", 32'(bad), 0);
        // single demand plus home recall
        sensor = 4'b0100;
        tick(2);
        sensor = 4'b0000;
        chk("req2_after_2_edges", 32'(req_pend[2]), 0);
        tick(1);
        chk("req2_after_3_edges", 32'(req_pend[2]), 1);
        hist.delete();
        wait_state(0, 2, 60);
        wait_state(0, 0, 60);
        chk("single_run_count", 32'(hist.size()), 6);
        chk_run(1, 1, 0, 3);
        chk_run(2, 2, 0, 2);
        chk_run(3, 0, 2, 8);
        chk_run(4, 1, 2, 3);
        chk_run(5, 2, 2, 2);
        // max-out: approach 0 re-enters green with its sensor held, then approach 1 competes
        sensor = 4'b1001;
        tick(2);
        sensor = 4'b0001;
        wait_state(0, 3, 80);
        wait_state(0, 0, 60);
        hist.delete();
        sensor = 4'b0011;
        tick(2);
        sensor = 4'b0001;
        wait_state(0, 1, 80);
        chk("maxout_run_count", 32'(hist.size()), 3);
        chk_run(0, 0, 0, 32);
        chk_run(1, 1, 0, 3);
        chk_run(2, 2, 0, 2);
        // round-robin wrap from approach 1 with demand on 0 and 3
        greens.delete();
        sensor = 4'b1001;
        tick(2);
        sensor = 4'b0000;
        wait_state(0, 3, 60);
        chk("rr_req_at_3", 32'(req_pend), 32'b0001);
        wait_state(0, 0, 60);
        chk("rr_green_count", 32'(greens.size()), 2);
        if (greens.size() == 2) begin
            chk("rr_first", 32'(greens[0]), 3);
            chk("rr_second", 32'(greens[1]), 0);
        end
        chk("rr_req_at_0", 32'(req_pend), 0);
        // reset mid-yellow with demand pending
        sensor = 4'b1100;
        tick(2);
        sensor = 4'b0000;
        wait_state(1, 0, 60);
        chk("pre_reset_req", 32'(req_pend), 32'b1100);
        rst_n = 1'b0;
        #1;
        chk("async_reset_light", 32'(light), 32'b100_100_100_001);
        chk("async_reset_phase", 32'(phase), 0);
        chk("async_reset_idx", 32'(active_idx), 0);
        chk("async_reset_req", 32'(req_pend), 0);
        tick(2);
        rst_n = 1'b1;
        // own-approach demand never latches while green
        sensor = 4'b0001;
        bad = 0;
        repeat (500) begin
            tick(1);
            if (req_pend[0] !== 1'b0 || phase !== 2'd0 || active_idx !== 2'd0) bad++;
        end
        chk("own_demand_bad_cycles", 32'(bad), 0);
        sensor = 4'b0000;
        tick(5);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
